fifo_arbiter: RTL
=================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter FIFO_WIDTH, default 32, data width of producers, consumer and FIFO port.
REQ-002 Parameter FIFO_DEPTH, default 8, entry count of the attached fifo_sync instance.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  producer write requests.
REQ-006 data0, data1  input  FIFO_WIDTH each  producer write data.
REQ-007 gnt0, gnt1  output  1 each  grant; data accepted at the closing posedge of the cycle in which it is high.
REQ-008 rd_req  input  1  consumer read request.
REQ-009 rd_valid  output  1  rd_data holds a popped word this cycle.
REQ-010 rd_data  output  FIFO_WIDTH  popped word.
REQ-011 level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-012 err  output  1  sticky flag for a flag/occupancy mismatch.
REQ-013 fifo_rst_n, fifo_cs, fifo_wr_en, fifo_rd_en  output  1 each  drive the FIFO control pins.
REQ-014 fifo_data_in  output  FIFO_WIDTH  drives the FIFO data_in pin.
REQ-015 fifo_data_out  input  FIFO_WIDTH  from the FIFO data_out pin.
REQ-016 fifo_full, fifo_empty  input  1 each  from the FIFO status pins.

Function
REQ-017 fifo_rst_n SHALL equal ~rst (combinational), so the FIFO resets in the same cycle as the arbiter.
REQ-018 Write eligibility SHALL be (req0|req1) && level<FIFO_DEPTH && !rst; the internal level counter gates writes, and fifo_full does not.
REQ-019 Arbitration SHALL be round-robin via a 1-bit last-grant register:
- With one requester, that requester wins.
- With both requesting, the one not granted last wins.
REQ-020 gnt0/gnt1 SHALL be combinational, one-hot or zero; fifo_wr_en = gnt0|gnt1; fifo_data_in = data of the granted port (data0 when no grant).
REQ-021 The last-grant register SHALL update only on cycles with a grant.
REQ-022 Read eligibility SHALL be rd_req && level>0 && !rst; fifo_rd_en equals read eligibility, combinational.
REQ-023 A write in the same cycle SHALL NOT make a read eligible at level 0.
REQ-024 A read in the same cycle SHALL NOT make a write eligible at level FIFO_DEPTH.
REQ-025 fifo_cs SHALL equal fifo_wr_en | fifo_rd_en.
REQ-026 rd_valid SHALL be a register loaded with fifo_rd_en, asserting exactly one cycle after each pop; rd_data = fifo_data_out (combinational).
REQ-027 level SHALL update at each posedge:
- +1 on write only.
- -1 on read only.
- Unchanged on simultaneous write and read, or on neither.
- Never below 0 or above FIFO_DEPTH.
REQ-028 err SHALL set on any cycle, outside reset, where (level==FIFO_DEPTH) != fifo_full or (level==0) != fifo_empty; it clears only on rst.
REQ-029 Back-to-back grants and back-to-back reads SHALL be supported, one per cycle each, with no bubble.

Reset
REQ-030 On rst high at a posedge, the following SHALL hold: level=0, rd_valid=0, err=0, last-grant=1 (port 0 wins the first contest).
REQ-031 While rst is high, gnt0/gnt1, fifo_wr_en, fifo_rd_en and fifo_cs SHALL be 0, regardless of requests.
REQ-032 Reset mid-transfer SHALL discard all FIFO content; data granted in the reset cycle is not written.

Verification
REQ-033 Basic path: req0 writes 1, 10, 100; then rd_req for 4 cycles -> rd_data 1, 10, 100 on consecutive rd_valid cycles; 4th request not popped; level 3->0; err=0.
REQ-034 Round-robin: req0 and req1 held high with data 0xA0 and 0xB1 for 8 cycles -> grants alternate starting with gnt0; FIFO holds A0,B1,A0,B1,...; level=8.
REQ-035 Full back-pressure: 9 single-port writes of 2**i -> first 8 granted, 9th gnt=0 while level=8; subsequent read of 8 -> 1,2,...,128 in order.
REQ-036 Simultaneous access: at level=4, write 0x55 and read in the same cycle -> level stays 4, oldest word returned, 0x55 is last out.
REQ-037 Empty boundary: at level=0, req0 and rd_req asserted together -> write granted, no pop, level=1; pop occurs next cycle.
REQ-038 Reset mid-operation: rst pulsed at level=5 -> level=0, rd_valid=0, fifo_empty=1 next cycle; the first contest after reset goes to port 0.

Source files
------------

// File: rtl/fifo_arbiter.sv
// Two-producer round-robin write arbiter and single-consumer read port in front of
// an external synchronous FIFO; keeps its own occupancy count and cross-checks the FIFO flags.
module fifo_arbiter #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0,
  input  logic                          req1,
  input  logic [FIFO_WIDTH-1:0]         data0,
  input  logic [FIFO_WIDTH-1:0]         data1,
  output logic                          gnt0,
  output logic                          gnt1,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic [FIFO_WIDTH-1:0]         rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          err,
  output logic                          fifo_rst_n,
  output logic                          fifo_cs,
  output logic                          fifo_wr_en,
  output logic                          fifo_rd_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic [FIFO_WIDTH-1:0]         fifo_data_out,
  input  logic                          fifo_full,
  input  logic                          fifo_empty
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [LW-1:0] level_q, level_d;
  logic          last_q, last_d;   // 1: port 1 was granted most recently
  logic          rd_valid_q;
  logic          err_q, err_d;
  logic          wr_ok, rd_ok, g0, g1;

  // Eligibility uses the local count only, so both sides see a single consistent occupancy.
  always_comb begin
    wr_ok  = (req0 | req1) && (level_q < FULL_LVL) && !rst;
    rd_ok  = rd_req && (level_q != '0) && !rst;
    g0     = wr_ok & req0 & (~req1 | last_q);
    g1     = wr_ok & req1 & (~req0 | ~last_q);

    last_d = last_q;
    if (g0)      last_d = 1'b0;
    else if (g1) last_d = 1'b1;

    level_d = level_q;
    case ({g0 | g1, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    err_d = err_q | ((level_q == FULL_LVL) != fifo_full) | ((level_q == '0) != fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= '0;
      last_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      level_q    <= level_d;
      last_q     <= last_d;
      rd_valid_q <= rd_ok;
      err_q      <= err_d;
    end
  end

  assign gnt0         = g0;
  assign gnt1         = g1;
  assign fifo_rst_n   = ~rst;
  assign fifo_wr_en   = g0 | g1;
  assign fifo_rd_en   = rd_ok;
  assign fifo_cs      = g0 | g1 | rd_ok;
  assign fifo_data_in = g1 ? data1 : data0;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = fifo_data_out;
  assign level        = level_q;
  assign err          = err_q;

endmodule
